// File: rtl/noc_rr_switch_alloc_if.sv
// rtl/noc_rr_switch_alloc_if.sv - input-side and output-side flit handshake bundle for one output port
interface noc_rr_switch_alloc_if #(
  parameter int N         = 5,
  parameter int DataWidth = 32
);
  logic [N-1:0]                in_valid;
  logic [N-1:0]                in_last;
  logic [N-1:0][DataWidth-1:0] in_data;
  logic [N-1:0]                in_ready;
  logic [N-1:0]                noc_case;
  logic                        out_valid;
  logic                        out_last;
  logic [DataWidth-1:0]        out_data;
  logic                        out_ready;

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, noc_case, out_valid, out_last, out_data
  );

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, noc_case, out_valid, out_last, out_data
  );
endinterface

// File: rtl/noc_rr_switch_alloc.sv
// rtl/noc_rr_switch_alloc.sv - round-robin wormhole switch allocator with registered output stage
// Grant is taken in IDLE, held head-to-tail in LOCKED, and released on the tail handshake.
module noc_rr_switch_alloc #(
  parameter int N         = 5,
  parameter int DataWidth = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_rr_switch_alloc_if.slave  bus
);
  localparam int IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state, state_next;
  logic [N-1:0]        case_q, case_next;
  logic [IdxW-1:0]     last_winner, last_winner_next;
  logic [IdxW-1:0]     winner, owner;
  logic                found;
  logic                accept_ok;
  logic                xfer;
  logic                tail;
  logic [DataWidth-1:0] owner_data;
  logic                out_valid_q, out_last_q;
  logic [DataWidth-1:0] out_data_q;

  assign accept_ok     = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = case_q & {N{accept_ok}};
  assign bus.noc_case  = case_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;

  assign xfer = |(bus.in_valid & bus.in_ready);
  assign tail = |(bus.in_last & case_q);

  // Two passes give the rotating priority: first above last_winner, then wrap to 0..last_winner.
  always_comb begin
    winner = last_winner;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && bus.in_valid[i] && (IdxW'(i) > last_winner)) begin
        winner = IdxW'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && bus.in_valid[i]) begin
        winner = IdxW'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    owner      = '0;
    owner_data = '0;
    for (int i = 0; i < N; i++) begin
      if (case_q[i]) begin
        owner = IdxW'(i);
      end
      owner_data = owner_data | (bus.in_data[i] & {DataWidth{case_q[i]}});
    end
  end

  always_comb begin
    state_next       = state;
    case_next        = case_q;
    last_winner_next = last_winner;
    case (state)
      IDLE: begin
        if (found) begin
          case_next  = N'(1) << winner;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer && tail) begin
          case_next        = '0;
          last_winner_next = owner;
          state_next       = IDLE;
        end
      end
      default: begin
        case_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      case_q      <= '0;
      last_winner <= IdxW'(N - 1);
    end else begin
      state       <= state_next;
      case_q      <= case_next;
      last_winner <= last_winner_next;
    end
  end

  // Fill takes precedence over drain so a simultaneous pop/push keeps the stage full.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_last_q  <= tail;
      out_data_q  <= owner_data;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_noc_rr_switch_alloc.sv
// tb/tb_noc_rr_switch_alloc.sv - scoreboard bench with packet-level round-robin reference model
module tb_noc_rr_switch_alloc;
  localparam int N  = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } flit_t;

  logic clk = 1'b0;
  logic rst;

  noc_rr_switch_alloc_if #(.N(N), .DataWidth(DW)) bus ();
  noc_rr_switch_alloc #(.N(N), .DataWidth(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  flit_t src_q[N][$];
  flit_t sb[$];
  int    hold[N];
  int    gap_first[N];
  bit    first[N];
  bit    rand_ready, rand_gaps, ready_fixed;
  int    model_last;
  int    tag;
  int    n_cmp, n_bad;
  int    flush_cnt, flush_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_pkt(input int i, input int len);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      tag++;
      f.data = {4'(i), 28'(tag)};
      f.last = (k == len - 1);
      src_q[i].push_back(f);
    end
  endtask

  // Whole-packet round robin over non-empty input queues, starting after the previous winner.
  task automatic model_expect();
    flit_t q[N][$];
    flit_t f;
    int    w;
    for (int i = 0; i < N; i++) q[i] = src_q[i];
    forever begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && q[(model_last + k) % N].size() > 0) w = (model_last + k) % N;
      end
      if (w < 0) break;
      do begin
        f = q[w].pop_front();
        sb.push_back(f);
      end while (!f.last);
      model_last = w;
    end
  endtask

  task automatic wait_idle(input int max);
    bit ok = 0;
    bit empty;
    for (int c = 0; c < max; c++) begin
      @(negedge clk); #1;
      empty = 1;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) empty = 0;
      if (empty && sb.size() == 0 && !bus.out_valid && bus.noc_case == '0) begin
        ok = 1;
        break;
      end
    end
    check("idle_timeout", ok, 1);
    if (!ok) begin
      sb.delete();
      flush_cnt++;
    end
  endtask

  // Upstream sources: present queue heads, pop on observed handshakes, insert gaps only mid-packet.
  initial begin
    logic [N-1:0] s_fire;
    bit           s_rst;
    flit_t        f;
    forever begin
      @(negedge clk);
      s_rst  = rst;
      s_fire = bus.in_valid & bus.in_ready;
      @(posedge clk); #1;
      if (flush_cnt != flush_seen) begin
        for (int i = 0; i < N; i++) begin
          src_q[i].delete();
          hold[i]  = 0;
          first[i] = 1;
        end
        flush_seen = flush_cnt;
      end
      for (int i = 0; i < N; i++) begin
        if (!s_rst && s_fire[i] && src_q[i].size() > 0) begin
          f = src_q[i].pop_front();
          if (!f.last) hold[i] = first[i] ? gap_first[i] : (rand_gaps ? int'($urandom_range(0, 2)) : 0);
          first[i] = f.last;
        end else if (hold[i] > 0) begin
          hold[i]--;
        end
        bus.in_valid[i] = (src_q[i].size() > 0) && (hold[i] == 0);
        bus.in_data[i]  = (src_q[i].size() > 0) ? src_q[i][0].data : '0;
        bus.in_last[i]  = (src_q[i].size() > 0) ? src_q[i][0].last : 1'b0;
      end
      bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end
  end

  // Monitor: output scoreboard plus per-cycle handshake and grant-lock rules.
  logic [N-1:0]  prev_case, prev_iv;
  logic [DW-1:0] prev_data;
  bit            prev_tail, prev_ov, prev_or;
  bit            prev_rst = 1;
  flit_t         exp_f;
  always @(negedge clk) begin
    if (!rst) begin
      check("onehot", ($countones(bus.noc_case) <= 1), 1);
      check("in_ready", bus.in_ready, bus.noc_case & {N{~bus.out_valid | bus.out_ready}});
      if (!prev_rst) begin
        if (prev_ov && !prev_or) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_data", bus.out_data, prev_data);
        end
        if (prev_case != '0) check("case_lock", bus.noc_case, prev_tail ? '0 : prev_case);
        else if (prev_iv != '0) check("arb_grant", (bus.noc_case != '0), 1);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_flit", {bus.out_data, bus.out_last}, 0);
        end else begin
          exp_f = sb.pop_front();
          check("out_flit", {bus.out_data, bus.out_last}, exp_f);
        end
      end
    end
    prev_rst  = rst;
    prev_case = bus.noc_case;
    prev_iv   = bus.in_valid;
    prev_tail = |(bus.in_valid & bus.in_ready & bus.in_last);
    prev_ov   = bus.out_valid;
    prev_or   = bus.out_ready;
    prev_data = bus.out_data;
  end

  initial begin
    logic [DW-1:0] d;
    int            np;
    bit            any;
    rst           = 1;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    ready_fixed   = 1;
    rand_ready    = 0;
    rand_gaps     = 0;
    model_last    = N - 1;
    for (int i = 0; i < N; i++) begin
      first[i]     = 1;
      hold[i]      = 0;
      gap_first[i] = 0;
    end

    // T1: reset held with all inputs requesting
    for (int i = 0; i < N; i++) load_pkt(i, 1);
    model_expect();
    repeat (2) begin
      @(negedge clk); #1;
      check("t1_case", bus.noc_case, 0);
      check("t1_ready", bus.in_ready, 0);
      check("t1_ovalid", bus.out_valid, 0);
    end
    rst = 0;
    wait_idle(200);

    // T2: priority and latency with in2/in4 two-flit packets
    load_pkt(2, 2);
    load_pkt(4, 2);
    model_expect();
    @(negedge clk); #1; check("t2_case_t", bus.noc_case, 5'b00000);
    @(negedge clk); #1; check("t2_case_t1", bus.noc_case, 5'b00100);
                        check("t2_ov_t1", bus.out_valid, 0);
    @(negedge clk); #1; check("t2_ov_t2", bus.out_valid, 1);
    @(negedge clk); #1; check("t2_case_t3", bus.noc_case, 5'b00000);
                        check("t2_last_t3", bus.out_last, 1);
    @(negedge clk); #1; check("t2_case_t4", bus.noc_case, 5'b10000);
    @(negedge clk); #1; check("t2_ov_t5", bus.out_valid, 1);
    wait_idle(200);

    // T3: fairness, every input offers two single-flit packets
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) load_pkt(i, 1);
    model_expect();
    wait_idle(200);

    // T4: backpressure mid-packet
    load_pkt(0, 6);
    model_expect();
    for (int c = 0; c < 50 && sb.size() > 4; c++) begin
      @(negedge clk); #1;
    end
    check("t4_progress", sb.size(), 4);
    ready_fixed = 0;
    @(negedge clk); #1;
    d = bus.out_data;
    check("t4_ov", bus.out_valid, 1);
    check("t4_ready", bus.in_ready, 0);
    repeat (3) begin
      @(negedge clk); #1;
      check("t4_ov", bus.out_valid, 1);
      check("t4_ready", bus.in_ready, 0);
      check("t4_data", bus.out_data, d);
    end
    ready_fixed = 1;
    wait_idle(200);

    // T5: lock held while owner in1 stalls and in0/in3 request
    gap_first[1] = 3;
    load_pkt(1, 4);
    load_pkt(0, 1);
    load_pkt(3, 1);
    model_expect();
    @(negedge clk); #1;
    @(negedge clk); #1; check("t5_grant", bus.noc_case, 5'b00010);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (src_q[1].size() == 0) break;
      check("t5_lock", bus.noc_case, 5'b00010);
    end
    gap_first[1] = 0;
    wait_idle(200);

    // T6: reset during flit 2 of a 4-flit packet on in3
    load_pkt(3, 4);
    model_expect();
    for (int c = 0; c < 50 && src_q[3].size() > 3; c++) begin
      @(negedge clk); #1;
    end
    check("t6_progress", src_q[3].size(), 3);
    rst = 1;
    @(negedge clk); #1;
    check("t6_case", bus.noc_case, 0);
    check("t6_ov", bus.out_valid, 0);
    sb.delete();
    flush_cnt++;
    model_last = N - 1;
    @(negedge clk); #1;
    rst = 0;
    load_pkt(0, 1);
    load_pkt(3, 1);
    model_expect();
    @(negedge clk); #1;
    @(negedge clk); #1; check("t6_regrant", bus.noc_case, 5'b00001);
    wait_idle(200);

    // Randomized phases: random packet mixes, output stalls and mid-packet gaps
    rand_ready = 1;
    rand_gaps  = 1;
    for (int p = 0; p < 30; p++) begin
      any = 0;
      for (int i = 0; i < N; i++) begin
        np = $urandom_range(0, 2);
        for (int k = 0; k < np; k++) begin
          load_pkt(i, $urandom_range(1, 4));
          any = 1;
        end
      end
      if (any) begin
        model_expect();
        wait_idle(600);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
